// File: rtl/demux1by8_deser.sv
// -----------------------------------------------------------------------------
// demux1by8_deser
//   1:8 serial-to-parallel deserializer. It is the receive-side counterpart of
//   an 8:1 mux that sends one bit per slot. A sync strobe aligns the frame, and
//   eight accepted samples then make up one byte.
//
// Parameters
//   LSB_FIRST   1: slot k lands in dout bit k; 0: slot k lands in bit 7-k
//
// Ports
//   clk         single clock; all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   en          sample strobe; din is consumed on an edge where en=1
//   sync        frame restart; the current sample is forced to slot 0
//   din         serial data in
//   dout[7:0]   last complete frame, registered, held between frames
//   slot[2:0]   slot that the next accepted sample will fill
//   frame_valid one-cycle pulse on the cycle that dout updates
//   locked      high once a sync has been seen since reset
// -----------------------------------------------------------------------------
module demux1by8_deser #(
    parameter int LSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sync,
    input  logic       din,
    output logic [7:0] dout,
    output logic [2:0] slot,
    output logic       frame_valid,
    output logic       locked
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] shadow_q, shadow_d;
    logic [2:0] slot_q, slot_d;
    logic [7:0] dout_q, dout_d;
    logic       fv_q, fv_d;
    logic [7:0] merged;

    // Maps a slot index onto its bit position in the frame.
    function automatic logic [2:0] map_f(input logic [2:0] s);
        return (LSB_FIRST != 0) ? s : (3'd7 - s);
    endfunction

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        slot_d   = slot_q;
        dout_d   = dout_q;
        fv_d     = 1'b0;

        // The shadow with this edge's sample already written in, so that a
        // completing frame includes its eighth bit.
        merged                = shadow_q;
        merged[map_f(slot_q)] = din;

        if (sync) begin
            // sync has priority over completing a frame: a partial frame is
            // discarded, even one sitting at slot 7.
            state_d  = LOCKED;
            shadow_d = 8'h00;
            slot_d   = 3'd0;
            if (en) begin
                shadow_d[map_f(3'd0)] = din;
                slot_d                = 3'd1;
            end
        end else if (state_q == LOCKED && en) begin
            if (slot_q == 3'd7) begin
                dout_d   = merged;
                fv_d     = 1'b1;
                shadow_d = 8'h00;
                slot_d   = 3'd0;
            end else begin
                shadow_d = merged;
                slot_d   = slot_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= HUNT;
            shadow_q <= 8'h00;
            slot_q   <= 3'd0;
            dout_q   <= 8'h00;
            fv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            slot_q   <= slot_d;
            dout_q   <= dout_d;
            fv_q     <= fv_d;
        end
    end

    assign dout        = dout_q;
    assign slot        = slot_q;
    assign frame_valid = fv_q;
    assign locked      = (state_q == LOCKED);

endmodule
